// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit common-anode seven-segment scan controller.
//   Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZB_EN.
//   Ports: System_clk clock; rst_n async active-low reset; en_i scan enable;
//   digits_i four BCD nibbles (digit 0 in [3:0]); dp_i per-digit decimal point;
//   ano active-low anodes; bcd_o shared decoder nibble; dp_o active-low dp;
//   digit_o current digit index; frame_o one-cycle frame-start (shadow load) pulse.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        System_clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  output logic [3:0]  ano,
  output logic [3:0]  bcd_o,
  output logic        dp_o,
  output logic [1:0]  digit_o,
  output logic        frame_o
);
  localparam int CW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [1:0] ndigit;
  logic [15:0] sh, nsh;
  logic [3:0] sdp, nsdp, lz;
  logic load;
  // Next-state values drive both the state registers and the registered
  // outputs, so the outputs line up with the state they describe.
  always_comb begin
    nstate = state;
    ncnt = cnt;
    ndigit = digit_o;
    load = 1'b0;
    if (!en_i) begin
      nstate = IDLE;
      ncnt = '0;
      ndigit = '0;
    end else if (state == IDLE) begin
      nstate = BLANK;
      load = 1'b1;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      nstate = BLANK;
      ncnt = '0;
      ndigit = digit_o + 2'd1;
      load = digit_o == 2'd3;
    end else begin
      ncnt = cnt + CW'(1);
      nstate = (cnt == CW'(BLANK_CYC - 1)) ? SHOW : state;
    end
  end
  assign nsh = load ? digits_i : sh;
  assign nsdp = load ? dp_i : sdp;
`ifdef SEG_SCAN_LZB_EN
  // A digit is a leading zero only if it and every digit above it are zero
  // with no decimal point; digit 0 always shows.
  assign lz[3] = nsh[15:12] == 4'd0 && !nsdp[3];
  assign lz[2] = lz[3] && nsh[11:8] == 4'd0 && !nsdp[2];
  assign lz[1] = lz[2] && nsh[7:4] == 4'd0 && !nsdp[1];
  assign lz[0] = 1'b0;
`else
  assign lz = 4'b0000;
`endif
  always_ff @(posedge System_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      sdp <= '0;
      ano <= 4'hf;
      bcd_o <= 4'h0;
      dp_o <= 1'b1;
      digit_o <= 2'd0;
      frame_o <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      sh <= nsh;
      sdp <= nsdp;
      ano <= (nstate == SHOW) ? (~(4'b0001 << ndigit) | lz) : 4'hf;
      bcd_o <= (nstate == IDLE) ? 4'h0 : nsh[{ndigit, 2'b00} +: 4];
      dp_o <= (nstate == IDLE) | ~nsdp[ndigit];
      digit_o <= ndigit;
      frame_o <= load;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
module tb_seg_scan_ctrl;
  logic System_clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_i = 1'b1;
  logic [15:0] digits_i = 16'h1234;
  logic [3:0] dp_i = 4'h0;
  logic [3:0] ano, bcd_o;
  logic dp_o, frame_o;
  logic [1:0] digit_o;
  int n_vec = 0;
  int n_err = 0;
`ifdef SEG_SCAN_LZB_EN
  localparam logic [3:0] LZM = 4'hf;
`else
  localparam logic [3:0] LZM = 4'h0;
`endif
  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .System_clk(System_clk), .rst_n(rst_n), .en_i(en_i), .digits_i(digits_i), .dp_i(dp_i),
    .ano(ano), .bcd_o(bcd_o), .dp_o(dp_o), .digit_o(digit_o), .frame_o(frame_o)
  );
  always #5 System_clk = ~System_clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Vector packing: {ano, bcd_o, dp_o, digit_o, frame_o}.
  task automatic check_frame(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] lz,
                             input int chg_at, input logic [15:0] chg_val);
    for (int i = 0; i < 32; i++) begin
      int d;
      int c;
      logic [3:0] ea;
      d = i / 8;
      c = i % 8;
      ea = (c < 2) ? 4'hf : (~(4'b0001 << d) | lz);
      @(negedge System_clk);
      chk($sformatf("scan_%h_%0d", dig, i), 16'({ano, bcd_o, dp_o, digit_o, frame_o}),
          16'({ea, dig[4*d +: 4], ~dp[d], 2'(d), i == 0}));
      chk($sformatf("onehot_%0d", i), 16'($countones(~ano) <= 1), 16'd1);
      if (i == chg_at) digits_i = chg_val;
    end
  endtask
  initial begin
    repeat (2) @(negedge System_clk);
    chk("reset", 16'({ano, bcd_o, dp_o, digit_o, frame_o}), 16'({4'hf, 4'h0, 1'b1, 2'd0, 1'b0}));
    rst_n = 1'b1;
    check_frame(16'h1234, 4'h0, 4'h0, -1, 16'h0);
    check_frame(16'h1234, 4'h0, 4'h0, 12, 16'h5678);
    check_frame(16'h5678, 4'h0, 4'h0, -1, 16'h0);
    repeat (20) @(negedge System_clk);
    chk("pre_drop", 16'({ano, digit_o}), 16'({4'b1011, 2'd2}));
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge System_clk);
      chk($sformatf("idle_%0d", k), 16'({ano, digit_o, frame_o}), 16'({4'hf, 2'd0, 1'b0}));
    end
    digits_i = 16'h0042;
    dp_i = 4'b0100;
    en_i = 1'b1;
    check_frame(16'h0042, 4'b0100, 4'b1000 & LZM, -1, 16'h0);
    repeat (5) @(negedge System_clk);
    chk("pre_rst", 16'({ano, bcd_o}), 16'({4'b1110, 4'h2}));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 16'({ano, bcd_o, dp_o, digit_o, frame_o}), 16'({4'hf, 4'h0, 1'b1, 2'd0, 1'b0}));
    @(negedge System_clk);
    chk("rst_hold", 16'({ano, bcd_o, frame_o}), 16'({4'hf, 4'h0, 1'b0}));
    digits_i = 16'h0007;
    dp_i = 4'h0;
    rst_n = 1'b1;
    check_frame(16'h0007, 4'h0, 4'b1110 & LZM, 3, 16'h0000);
    check_frame(16'h0000, 4'h0, 4'b1110 & LZM, -1, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
